// File: rtl/des_feistel_engine.sv
// rtl/des_feistel_engine.sv - iterative single/EDE Feistel engine with CBC, input FIFO and ready/valid output
module des_feistel_engine #(
    parameter int BLOCK_W    = 64,
    parameter int ROUNDS     = 16,
    parameter int PASSES     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BLOCK_W-1:0]         in_data,
    input  logic                       encrypt,
    input  logic                       cbc_en,
    input  logic                       iv_load,
    input  logic [BLOCK_W-1:0]         iv_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_W-1:0]         out_data,
    output logic                       busy,
    output logic [BLOCK_W/2-1:0]       f_r,
    output logic [$clog2(ROUNDS)-1:0]  f_round,
    output logic [1:0]                 f_key_sel,
    input  logic [BLOCK_W/2-1:0]       f_out
);

    localparam int HW = BLOCK_W / 2;
    localparam int RW = $clog2(ROUNDS);
    localparam int EW = BLOCK_W + 2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} fsm_t;

    fsm_t               fsm, fsm_nxt;
    logic               enc_meta, enc_sync;
    logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      fifo_cnt;
    logic               fifo_empty, fifo_full, push, pop;
    logic [EW-1:0]      head;
    logic [BLOCK_W-1:0] in_hold, state_q, chain_q, out_data_q, result;
    logic               enc_q, cbc_q, out_valid_q;
    logic [1:0]         pass_q, key_sel;
    logic [RW-1:0]      rnd_q, cur_round;
    logic [HW-1:0]      l_half, r_half, mixed, f_r_q;
    logic [RW-1:0]      f_round_q;
    logic [1:0]         f_key_q;
    logic               last_rnd, last_pass, fwd, in_round, can_write, wr_out, iv_take;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign push       = in_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr];

    assign l_half     = state_q[BLOCK_W-1:HW];
    assign r_half     = state_q[HW-1:0];
    assign mixed      = l_half ^ f_out;
    assign last_rnd   = (rnd_q == RW'(ROUNDS - 1));
    assign last_pass  = (pass_q == 2'(PASSES - 1));
    // Even passes run in the block's own direction, odd passes in the opposite one.
    assign fwd        = enc_q ? ~pass_q[0] : pass_q[0];
    assign key_sel    = enc_q ? pass_q : 2'(PASSES - 1) - pass_q;
    assign cur_round  = fwd ? rnd_q : RW'(ROUNDS - 1) - rnd_q;
    assign in_round   = (fsm == ROUND);

    assign can_write  = !out_valid_q || out_ready;
    assign wr_out     = (fsm == DONE) && can_write;
    assign result     = (cbc_q && !enc_q) ? (state_q ^ chain_q) : state_q;
    assign iv_take    = iv_load && (fsm == IDLE) && fifo_empty;

    assign in_ready   = !fifo_full;
    assign busy       = (fsm != IDLE) || !fifo_empty;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    // F sees the live right half during rounds and the last presented values otherwise.
    assign f_r        = in_round ? r_half    : f_r_q;
    assign f_round    = in_round ? cur_round : f_round_q;
    assign f_key_sel  = in_round ? key_sel   : f_key_q;

    // Two-flop synchroniser for the asynchronous mode level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            enc_meta <= 1'b0;
            enc_sync <= 1'b0;
        end else begin
            enc_meta <= encrypt;
            enc_sync <= enc_meta;
        end
    end

    // FIFO storage: data with the mode bits captured at push time.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_data, enc_sync, cbc_en};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next state and pop; DONE pops directly so back-to-back blocks skip IDLE.
    always_comb begin
        fsm_nxt = fsm;
        pop     = 1'b0;
        case (fsm)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    fsm_nxt = LOAD;
                end
            end
            LOAD: fsm_nxt = ROUND;
            ROUND: begin
                if (last_rnd && last_pass) begin
                    fsm_nxt = DONE;
                end
            end
            DONE: begin
                if (can_write) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        fsm_nxt = LOAD;
                    end else begin
                        fsm_nxt = IDLE;
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Block datapath: capture on pop, CBC pre-whitening in LOAD, one Feistel round per ROUND cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_hold <= '0;
            enc_q   <= 1'b0;
            cbc_q   <= 1'b0;
            state_q <= '0;
            pass_q  <= '0;
            rnd_q   <= '0;
        end else begin
            if (pop) begin
                in_hold <= head[EW-1:2];
                enc_q   <= head[1];
                cbc_q   <= head[0];
            end
            if (fsm == LOAD) begin
                state_q <= (enc_q && cbc_q) ? (in_hold ^ chain_q) : in_hold;
                pass_q  <= '0;
                rnd_q   <= '0;
            end else if (in_round) begin
                if (last_rnd) begin
                    state_q <= {mixed, r_half};
                    rnd_q   <= '0;
                    if (!last_pass) begin
                        pass_q <= pass_q + 2'd1;
                    end
                end else begin
                    state_q <= {r_half, mixed};
                    rnd_q   <= rnd_q + RW'(1);
                end
            end
        end
    end

    // Result register and output handshake.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (wr_out) begin
            out_data_q  <= result;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // CBC chain: IV load when fully idle, otherwise advanced by each written CBC block.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain_q <= '0;
        end else if (iv_take) begin
            chain_q <= iv_data;
        end else if (wr_out && cbc_q) begin
            chain_q <= enc_q ? state_q : in_hold;
        end
    end

    // Hold the last values presented to F so they stay put outside ROUND.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            f_r_q     <= '0;
            f_round_q <= '0;
            f_key_q   <= '0;
        end else if (in_round) begin
            f_r_q     <= r_half;
            f_round_q <= cur_round;
            f_key_q   <= key_sel;
        end
    end

endmodule
